nmr_bstrm_seq_ctrl: RTL

//  Sequencer feeding the NMR bitstream datapath: reads packed pulse words from a sync-read

---
 rtl/nmr_bstrm_seq_ctrl.sv | 233 +++++++++++++++++++++++
 1 files changed

// File: rtl/nmr_bstrm_seq_ctrl.sv
// Sequencer between the pulse-sequence RAM and the NMR bitstream datapath: fetches packed words,
// hands them to the datapath with a START strobe, waits for DPATH_RDY, loops and times out.
module nmr_bstrm_seq_ctrl #(
    parameter int unsigned DATA_WIDTH = 24,
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned RD_LAT     = 2,
    parameter int unsigned INIT_BLANK = 50,
    parameter int unsigned TO_MARGIN  = 64
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  go_i,
    input  logic                  abort_i,
    input  logic [7:0]            loop_cnt_i,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic                  mem_rd_o,
    input  logic [DATA_WIDTH+5:0] mem_rdata_i,
    output logic                  dp_rst_o,
    output logic                  start_o,
    input  logic                  dpath_rdy_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  pls_pol_o,
    output logic [3:0]            mux_sel_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o
);

    localparam int unsigned ToW = DATA_WIDTH + 8;

    typedef enum logic [2:0] {
        StIdle,
        StDprst,
        StFetch,
        StLoad,
        StWait,
        StAbrt
    } state_e;

    state_e                state_q, state_d;
    logic [7:0]            cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [7:0]            loops_q, loops_d;
    logic [DATA_WIDTH-1:0] prev_len_q, prev_len_d;
    logic [ToW-1:0]        to_q, to_d;
    logic                  end_q, end_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  pol_q, pol_d;
    logic [3:0]            sel_q, sel_d;
    logic                  mem_rd_q, mem_rd_d;
    logic                  dp_rst_q, dp_rst_d;
    logic                  start_q, start_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        loops_d    = loops_q;
        prev_len_d = prev_len_q;
        to_d       = to_q;
        end_d      = end_q;
        data_d     = data_q;
        pol_d      = pol_q;
        sel_d      = sel_q;
        mem_rd_d   = 1'b0;
        dp_rst_d   = 1'b0;
        start_d    = 1'b0;
        busy_d     = busy_q;
        done_d     = done_q;
        err_d      = err_q;

        // ABORT pre-empts everything else so no addr/prev_len update leaks through.
        if (abort_i && (state_q != StIdle) && (state_q != StAbrt)) begin
            state_d  = StAbrt;
            cnt_d    = 8'd0;
            dp_rst_d = 1'b1;
            busy_d   = 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (go_i) begin
                        state_d    = StDprst;
                        cnt_d      = 8'd0;
                        done_d     = 1'b0;
                        err_d      = 1'b0;
                        loops_d    = (loop_cnt_i == 8'd0) ? 8'd1 : loop_cnt_i;
                        addr_d     = '0;
                        prev_len_d = DATA_WIDTH'(INIT_BLANK);
                        busy_d     = 1'b1;
                        dp_rst_d   = 1'b1;
                    end
                end

                StDprst: begin
                    if (cnt_q == 8'd0) begin
                        cnt_d    = 8'd1;
                        dp_rst_d = 1'b1;
                    end else begin
                        state_d  = StFetch;
                        cnt_d    = 8'd0;
                        mem_rd_d = 1'b1;
                    end
                end

                StFetch: begin
                    // cnt_q counts cycles since the read strobe; rdata is valid at RD_LAT.
                    if (cnt_q == 8'(RD_LAT)) begin
                        state_d = StLoad;
                        cnt_d   = 8'd0;
                        data_d  = mem_rdata_i[DATA_WIDTH-1:0];
                        sel_d   = mem_rdata_i[DATA_WIDTH+3:DATA_WIDTH];
                        pol_d   = mem_rdata_i[DATA_WIDTH+4];
                        end_d   = mem_rdata_i[DATA_WIDTH+5];
                        start_d = 1'b1;
                        to_d    = ToW'(prev_len_q) + ToW'(TO_MARGIN);
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end

                StLoad: begin
                    state_d = StWait;
                end

                StWait: begin
                    if (dpath_rdy_i) begin
                        prev_len_d = data_q;
                        if (!end_q) begin
                            if (addr_q == '1) begin
                                state_d  = StAbrt;
                                cnt_d    = 8'd0;
                                err_d    = 1'b1;
                                busy_d   = 1'b0;
                                dp_rst_d = 1'b1;
                            end else begin
                                state_d  = StFetch;
                                cnt_d    = 8'd0;
                                addr_d   = addr_q + 1'b1;
                                mem_rd_d = 1'b1;
                            end
                        end else if (loops_q > 8'd1) begin
                            state_d  = StFetch;
                            cnt_d    = 8'd0;
                            loops_d  = loops_q - 8'd1;
                            addr_d   = '0;
                            mem_rd_d = 1'b1;
                        end else begin
                            state_d = StIdle;
                            done_d  = 1'b1;
                            busy_d  = 1'b0;
                        end
                    end else if (to_q <= ToW'(1)) begin
                        // Last permitted WAIT cycle passed without the datapath answering.
                        state_d  = StAbrt;
                        cnt_d    = 8'd0;
                        err_d    = 1'b1;
                        busy_d   = 1'b0;
                        dp_rst_d = 1'b1;
                    end else begin
                        to_d = to_q - ToW'(1);
                    end
                end

                StAbrt: begin
                    if (cnt_q == 8'd0) begin
                        cnt_d    = 8'd1;
                        dp_rst_d = 1'b1;
                    end else begin
                        state_d = StIdle;
                        cnt_d   = 8'd0;
                    end
                end

                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= StIdle;
            cnt_q      <= 8'd0;
            addr_q     <= '0;
            loops_q    <= 8'd0;
            prev_len_q <= DATA_WIDTH'(INIT_BLANK);
            to_q       <= '0;
            end_q      <= 1'b0;
            data_q     <= '0;
            pol_q      <= 1'b0;
            sel_q      <= 4'd0;
            mem_rd_q   <= 1'b0;
            dp_rst_q   <= 1'b0;
            start_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            loops_q    <= loops_d;
            prev_len_q <= prev_len_d;
            to_q       <= to_d;
            end_q      <= end_d;
            data_q     <= data_d;
            pol_q      <= pol_d;
            sel_q      <= sel_d;
            mem_rd_q   <= mem_rd_d;
            dp_rst_q   <= dp_rst_d;
            start_q    <= start_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign mem_addr_o = addr_q;
    assign mem_rd_o   = mem_rd_q;
    assign dp_rst_o   = dp_rst_q;
    assign start_o    = start_q;
    assign data_o     = data_q;
    assign pls_pol_o  = pol_q;
    assign mux_sel_o  = sel_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign err_o      = err_q;

endmodule
